bus_timer: RTL
==============

# bus_timer

Memory-mapped timer peripheral on the data-memory bus of the multi-cycle processor, alongside data memory. Holds reload (TH), counter (TL) and control (TCON) registers plus an optional free-running SysTick counter. Raises a level interrupt to the controller when TL overflows with interrupts enabled. Software polls or clears it through ordinary `lw`/`sw` accesses.

## Interface
- `BASE_ADDR`, 32'h4000_0000: word-aligned base; block decodes `BASE_ADDR` .. `BASE_ADDR+0x1F`.
- `PRESCALE`, 1: TL advances once every `PRESCALE` enabled cycles; legal range 1..65535.

- `clk` input 1: the single clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-low; sampled on rising edge of `clk`.
- `addr` input 32: byte address from the processor data path.
- `wdata` input 32: store data.
- `mem_write` input 1: store strobe, one cycle per store.
- `mem_read` input 1: load strobe.
- `rdata` output 32: combinational read data; 0 when `mem_read`=0 or address unmapped.
- `hit` output 1: combinational; `addr` lies inside the decoded window; top-level mux selects `rdata` over data memory.
- `irq` output 1: equals TCON[2].

## Operation
- Decode: `hit` = (`addr[31:5]` == `BASE_ADDR[31:5]`); `addr[1:0]` ignored; register select `addr[4:2]`.
  - 0 TH; 1 TL; 2 TCON; 5 SYSTICK; 3, 4, 6, 7 reserved (read 0, writes ignored).
- TCON bits:
  - [0] count enable; [1] interrupt enable; [2] interrupt status.
  - [31:3] read 0.
  - A store writes [2:0] directly; writing 0 to [2] clears the interrupt.
- Prescaler: counter `pre_cnt` 0..PRESCALE-1, advances only while TCON[0]=1. A tick is asserted when `pre_cnt`==PRESCALE-1; `pre_cnt` then returns to 0.
- `pre_cnt` forced to 0 by: reset, TCON[0]=0, any store to TL.
- On each tick:
  - TL==32'hFFFF_FFFF: TL <= TH, and TCON[2] <= 1 if TCON[1]=1.
  - Otherwise TL <= TL+1.
- 32-bit unsigned arithmetic; no saturation.
- SYSTICK: increments every cycle regardless of TCON; wraps 32'hFFFF_FFFF -> 0; read-only.
- Simultaneous events, same edge:
  - Store to TL and tick: store wins; no overflow processing.
  - Store to TH and overflow reload: reload uses the old TH; the new TH is visible afterward.
  - Store to TCON clearing [2] and overflow setting [2]: set wins; the interrupt is never lost.
  - Store to TCON clearing [0] and tick: tick is completed this edge; no further ticks.
- `mem_read` and `mem_write` both high: the store is performed; `rdata` shows the pre-edge value.

## Timing
- Reset values: TH=0, TL=0, TCON=0, SYSTICK=0, `pre_cnt`=0. Outputs: `irq`=0, `rdata`=0 (no read).
- Reset takes effect at the first rising edge with `reset`=0 and overrides all stores and ticks. Mid-count reset discards the count.
- Stores take effect at the edge where `mem_write`=1; readable in the following cycle.
- Reads are zero-latency combinational and reflect register state before the edge; the processor latches them into MDR at its normal read-state edge.
- With PRESCALE=1 and TCON[0]=1: TL advances every cycle.
- Overflow: TCON[2] and `irq` rise at the edge that reloads TL, i.e. exactly one tick after TL reads 32'hFFFF_FFFF.
- `irq` remains high until software clears it or reset asserts.

## Configuration
- `BUS_TIMER_SYSTICK_EN` defined: SYSTICK register and its 32-bit counter are present at offset 0x14.
- Not defined: no counter logic; offset 0x14 reads 0 and is treated as reserved.

## Structure
- Package `bus_timer_pkg` holds:
  - Register offset constants: `TIMER_TH_OFS`=0x0, `TIMER_TL_OFS`=0x4, `TIMER_TCON_OFS`=0x8, `TIMER_SYSTICK_OFS`=0x14.
  - TCON bit index constants: `TCON_EN`=0, `TCON_IE`=1, `TCON_IS`=2.
- Sub-module `timer_prescaler`:
  - Parameter `PRESCALE`.
  - Inputs `clk`, `reset`, `enable`, `clear`; output `tick`.
  - Counter width `$clog2(PRESCALE)`, minimum 1.
- The register file, decode and overflow logic stay in `bus_timer`.

## Test plan
- Reset with `reset`=0 for 2 cycles, then read all offsets -> every read returns 0 and `irq`=0.
- Store TH=0xFFFF_FFF0 and TL=0xFFFF_FFFD, store TCON=3, PRESCALE=1:
  - TL reads 0xFFFF_FFFE, then 0xFFFF_FFFF, then 0xFFFF_FFF0; `irq` rises on the reload edge.
  - Store TCON=3 (bit2=0) -> `irq`=0 the next cycle.
- Overflow edge coinciding with a store TCON=3 -> `irq` still 1 afterward.
- PRESCALE=4, TL=0, TCON=1, run 12 cycles -> TL=3; store TL=10 mid-period -> next increment exactly 4 enabled cycles later.
- TCON[1]=0 with overflow -> TL reloads from TH and `irq` stays 0.
- `BUS_TIMER_SYSTICK_EN` defined: read 0x4000_0014 at two points 100 cycles apart -> difference 100.
  - Undefined: reads 0.
  - Reads of 0x4000_000C and 0x4000_0020 -> 0, and `hit`=1 and 0 respectively.

Source files
------------

// File: rtl/bus_timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus_timer_pkg
//  Description : Shared constants for the bus_timer peripheral: register
//                byte offsets, TCON bit positions and a register-select
//                helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package bus_timer_pkg;

  // Byte offsets of the architected registers inside the 32-byte window
  localparam logic [4:0] TIMER_TH_OFS      = 5'h00;
  localparam logic [4:0] TIMER_TL_OFS      = 5'h04;
  localparam logic [4:0] TIMER_TCON_OFS    = 5'h08;
  localparam logic [4:0] TIMER_SYSTICK_OFS = 5'h14;

  // TCON bit positions
  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_IS = 2;

  // Word index (addr[4:2]) that selects the register at a byte offset
  function automatic logic [2:0] reg_sel(input logic [4:0] ofs);
    return ofs[4:2];
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_timer_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : timer_prescaler
//  Description : Divides enabled cycles by PRESCALE. Emits a one-cycle tick
//                on the last count of each period; the count is held at zero
//                while disabled or when cleared.
//  Revision    : 1.0 - initial release
// ============================================================================
module timer_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  // A PRESCALE of 1 still needs a one-bit counter to keep the port widths legal
  localparam int            C_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [C_W-1:0] C_LAST = C_W'(PRESCALE - 1);

  logic [C_W-1:0] r_cnt;

  assign tick = enable && (r_cnt == C_LAST);

  // Period counter: restarts on reset, disable, clear, or end of period
  always_ff @(posedge clk) begin
    if (!reset || clear || !enable || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bus_timer.sv
`default_nettype none
// ============================================================================
//  Module      : bus_timer
//  Description : Memory-mapped timer on the data-memory bus. Reload (TH),
//                counter (TL) and control (TCON) registers; level interrupt
//                on TL overflow. Optional free-running SYSTICK counter at
//                offset 0x14, present when BUS_TIMER_SYSTICK_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_timer
  import bus_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int          PRESCALE  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_write,
  input  logic        mem_read,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        irq
);

  logic [31:0] r_th;
  logic [31:0] r_tl;
  logic [2:0]  r_tcon;
  logic [2:0]  w_tcon_next;
  logic [31:0] w_systick;
  logic [2:0]  w_sel;
  logic        w_wr;
  logic        w_wr_th;
  logic        w_wr_tl;
  logic        w_wr_tcon;
  logic        w_tick;
  logic        w_tl_max;
  logic        w_ovf;
  logic        w_unused_addr;

  // Byte lanes are irrelevant: every register is a full word
  assign w_unused_addr = ^addr[1:0];

  assign hit       = (addr[31:5] == BASE_ADDR[31:5]);
  assign w_sel     = addr[4:2];
  assign w_wr      = mem_write && hit;
  assign w_wr_th   = w_wr && (w_sel == reg_sel(TIMER_TH_OFS));
  assign w_wr_tl   = w_wr && (w_sel == reg_sel(TIMER_TL_OFS));
  assign w_wr_tcon = w_wr && (w_sel == reg_sel(TIMER_TCON_OFS));

  timer_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (r_tcon[TCON_EN]),
    .clear  (w_wr_tl),
    .tick   (w_tick)
  );

  // A software store to TL pre-empts the tick, so it also suppresses overflow
  assign w_tl_max = (r_tl == 32'hFFFF_FFFF);
  assign w_ovf    = w_tick && !w_wr_tl && w_tl_max;

  // TCON update: store first, then a pending overflow sets IS so it is never lost
  always_comb begin
    w_tcon_next = r_tcon;
    if (w_wr_tcon) begin
      w_tcon_next = wdata[2:0];
    end
    if (w_ovf && r_tcon[TCON_IE]) begin
      w_tcon_next[TCON_IS] = 1'b1;
    end
  end

  // Register file: TH store, TL store/count/reload, TCON
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_th   <= '0;
      r_tl   <= '0;
      r_tcon <= '0;
    end else begin
      if (w_wr_th) begin
        r_th <= wdata;
      end
      if (w_wr_tl) begin
        r_tl <= wdata;
      end else if (w_tick) begin
        // Reload reads TH before any same-edge TH store lands
        r_tl <= w_tl_max ? r_th : r_tl + 32'd1;
      end
      r_tcon <= w_tcon_next;
    end
  end

`ifdef BUS_TIMER_SYSTICK_EN
  logic [31:0] r_systick;

  // Free-running cycle counter, independent of TCON
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_systick <= '0;
    end else begin
      r_systick <= r_systick + 32'd1;
    end
  end

  assign w_systick = r_systick;
`else
  assign w_systick = '0;
`endif

  assign irq = r_tcon[TCON_IS];

  // Zero-latency read mux; unmapped, reserved or idle reads return zero
  always_comb begin
    rdata = '0;
    if (mem_read && hit) begin
      if (w_sel == reg_sel(TIMER_TH_OFS)) begin
        rdata = r_th;
      end else if (w_sel == reg_sel(TIMER_TL_OFS)) begin
        rdata = r_tl;
      end else if (w_sel == reg_sel(TIMER_TCON_OFS)) begin
        rdata = {29'd0, r_tcon};
      end else if (w_sel == reg_sel(TIMER_SYSTICK_OFS)) begin
        rdata = w_systick;
      end
    end
  end

endmodule
`default_nettype wire
